// File: rtl/ln_requant_pack.sv
// ln_requant_pack: int32 -> int8 requantizer with rounding shift, saturation, lane packer and overrun-flagging output FIFO
module ln_requant_pack #(
  parameter int D_W        = 8,
  parameter int D_W_ACC    = 32,
  parameter int N          = 768,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              in_valid,
  input  logic signed [D_W_ACC-1:0]         qin,
  input  logic signed [D_W_ACC-1:0]         mult,
  input  logic        [5:0]                 shift,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic        [LANES*D_W-1:0]       out_data,
  output logic                              out_last,
  output logic        [$clog2(FIFO_DEPTH):0] level,
  output logic                              overflow
);
  localparam int PW = 2 * D_W_ACC;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = LANES * D_W;
  localparam logic signed [PW:0] SMAX = $signed({{(PW + 2 - D_W){1'b0}}, {(D_W - 1){1'b1}}});
  localparam logic signed [PW:0] SMIN = $signed({{(PW + 2 - D_W){1'b1}}, {(D_W - 1){1'b0}}});

  logic                 s1_v, s1_last, s2_v, s2_last, s3_v, s3_last;
  logic signed [PW-1:0] s1_p;
  logic signed [PW:0]   s2_r, rnd, sum, r;
  logic [D_W-1:0]       s3_q, sat;
  logic [CW-1:0]        elem_cnt;
  logic [LW-1:0]        lane_idx;
  logic [WW-1:0]        word, merged;
  logic                 done, push, pop, full, wr;
  logic [WW:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        wp, rp;

  // S1: capture the full-width product and whether this element closes the vector
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_v     <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
      elem_cnt <= '0;
    end else if (enable) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_p     <= PW'(qin) * PW'(mult);
        s1_last  <= elem_cnt == CW'(N - 1);
        elem_cnt <= elem_cnt == CW'(N - 1) ? '0 : elem_cnt + CW'(1);
      end
    end

  // Round half toward +inf with one guard bit so the bias add cannot wrap, then saturate S2 result to int8
  always_comb begin
    rnd    = shift == 6'd0 ? '0 : (PW + 1)'(1) << (shift - 6'd1);
    sum    = {s1_p[PW-1], s1_p} + rnd;
    r      = sum >>> shift;
    sat    = s2_r > SMAX ? SMAX[D_W-1:0] : s2_r < SMIN ? SMIN[D_W-1:0] : s2_r[D_W-1:0];
    merged = word | (WW'(s3_q) << (lane_idx * D_W));
    done   = s3_v && (lane_idx == LW'(LANES - 1) || s3_last);
    push   = enable && done;
    full   = level == (AW + 1)'(FIFO_DEPTH);
    pop    = out_valid && out_ready;
    wr     = push && (!full || pop);
  end

  // S2/S3: rounded value, then saturated int8, each with its valid and last tag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_r    <= '0;
      s3_v    <= 1'b0;
      s3_last <= 1'b0;
      s3_q    <= '0;
    end else if (enable) begin
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_r    <= r;
      s3_v    <= s2_v;
      s3_last <= s2_last;
      s3_q    <= sat;
    end

  // Packer: accumulate lanes; a completed word restarts empty so a partial final word has zero upper lanes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lane_idx <= '0;
      word     <= '0;
    end else if (enable && s3_v) begin
      lane_idx <= done ? '0 : lane_idx + LW'(1);
      word     <= done ? '0 : merged;
    end

  // FIFO storage; contents are only read once written, so no reset is needed
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {s3_last, merged};

  // FIFO pointers, occupancy and sticky drop flag; the read side runs regardless of enable
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      level    <= wr && !pop ? level + (AW + 1)'(1) : !wr && pop ? level - (AW + 1)'(1) : level;
      overflow <= overflow | (push && full && !pop);
    end

  assign out_valid = level != '0;
  assign out_data  = out_valid ? mem[rp][WW-1:0] : '0;
  assign out_last  = out_valid & mem[rp][WW];
endmodule

// File: tb/tb_ln_requant_pack.sv
// tb_ln_requant_pack: directed table-driven checks of requant, packing, FIFO overflow, stall and reset
module tb_ln_requant_pack;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [31:0] qin = '0, mult = '0;
  logic [5:0] shift = '0;
  logic a_valid, a_last, a_ovf, b_valid, b_last, b_ovf;
  logic [31:0] a_data, b_data;
  logic [4:0] a_level, b_level;
  int checks = 0, failures = 0;

  typedef struct {
    logic signed [31:0] qin;
    logic signed [31:0] mult;
    logic [5:0]         shift;
    logic [7:0]         exp;
  } vec_t;
  vec_t tbl[20];

  always #5 clk = ~clk;

  ln_requant_pack #(.N(4)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .qin(qin), .mult(mult),
    .shift(shift), .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_last(a_last), .level(a_level), .overflow(a_ovf)
  );

  ln_requant_pack #(.N(6)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .qin(qin), .mult(mult),
    .shift(shift), .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_last(b_last), .level(b_level), .overflow(b_ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [31:0] q);
    qin = q;
    in_valid = 1'b1;
    tick;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    out_ready = 1'b0;
    enable = 1'b1;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic pop;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (!a_valid && n < 40) begin
      tick;
      n++;
    end
    chk("a out_valid arrives", a_valid, 1);
  endtask

  function automatic logic [31:0] wd(input int w);
    return {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] expw;
    logic [31:0] exp_b[3];
    logic        exp_bl[3];
    tbl[0]  = '{32'sd5,          32'sd65536, 6'd16, 8'h05};
    tbl[1]  = '{-32'sd3,         32'sd65536, 6'd16, 8'hFD};
    tbl[2]  = '{32'sd130,        32'sd65536, 6'd16, 8'h7F};
    tbl[3]  = '{-32'sd200,       32'sd65536, 6'd16, 8'h80};
    tbl[4]  = '{32'sd3,          32'sd1,     6'd1,  8'h02};
    tbl[5]  = '{-32'sd3,         32'sd1,     6'd1,  8'hFF};
    tbl[6]  = '{32'sd2,          32'sd1,     6'd1,  8'h01};
    tbl[7]  = '{-32'sd1,         32'sd1,     6'd1,  8'h00};
    tbl[8]  = '{-32'sd7,         32'sd1,     6'd0,  8'hF9};
    tbl[9]  = '{32'sd127,        32'sd1,     6'd0,  8'h7F};
    tbl[10] = '{32'sd128,        32'sd1,     6'd0,  8'h7F};
    tbl[11] = '{-32'sd129,       32'sd1,     6'd0,  8'h80};
    tbl[12] = '{32'sd10,         -32'sd3,    6'd2,  8'hF9};
    tbl[13] = '{-32'sd10,        -32'sd3,    6'd2,  8'h08};
    tbl[14] = '{32'sd1,          -32'sd3,    6'd2,  8'hFF};
    tbl[15] = '{32'sd0,          -32'sd3,    6'd2,  8'h00};
    tbl[16] = '{32'h80000000,    32'h80000000, 6'd63, 8'h01};
    tbl[17] = '{32'h7FFFFFFF,    32'h80000000, 6'd63, 8'h00};
    tbl[18] = '{32'sd0,          32'h80000000, 6'd63, 8'h00};
    tbl[19] = '{32'h80000000,    32'h80000000, 6'd63, 8'h01};

    tick;
    tick;
    chk("reset out_valid", a_valid, 0);
    chk("reset out_data", a_data, 0);
    chk("reset out_last", a_last, 0);
    chk("reset level", a_level, 0);
    chk("reset overflow", a_ovf, 0);
    rst = 1'b1;
    tick;

    for (int v = 0; v < 5; v++) begin
      mult = tbl[4 * v].mult;
      shift = tbl[4 * v].shift;
      expw = '0;
      for (int e = 0; e < 4; e++) begin
        send(tbl[4 * v + e].qin);
        expw[8 * e +: 8] = tbl[4 * v + e].exp;
      end
      in_valid = 1'b0;
      wait_a(n);
      if (v == 0) chk("first word latency", n, 3);
      chk($sformatf("vec%0d data", v), a_data, expw);
      chk($sformatf("vec%0d last", v), a_last, 1);
      chk($sformatf("vec%0d level", v), a_level, 1);
      pop;
    end

    do_reset;
    mult = 32'sd1;
    shift = 6'd0;
    for (int i = 1; i <= 6; i++) send(i);
    for (int i = 1; i <= 4; i++) send(i);
    in_valid = 1'b0;
    repeat (4) tick;
    chk("partial level", b_level, 3);
    exp_b[0] = 32'h04030201; exp_bl[0] = 1'b0;
    exp_b[1] = 32'h00000605; exp_bl[1] = 1'b1;
    exp_b[2] = 32'h04030201; exp_bl[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("partial word%0d data", k), b_data, exp_b[k]);
      chk($sformatf("partial word%0d last", k), b_last, exp_bl[k]);
      pop;
    end
    chk("partial drained", b_valid, 0);

    do_reset;
    for (int w = 0; w < 17; w++)
      for (int l = 0; l < 4; l++) send(4 * w + l);
    in_valid = 1'b0;
    repeat (4) tick;
    chk("overrun level", a_level, 16);
    chk("overrun flag", a_ovf, 1);
    for (int w = 0; w < 16; w++) begin
      chk($sformatf("drain word%0d", w), a_data, wd(w));
      pop;
    end
    chk("drained empty", a_valid, 0);
    chk("overflow sticky", a_ovf, 1);

    do_reset;
    chk("overflow cleared by reset", a_ovf, 0);
    for (int w = 0; w < 16; w++)
      for (int l = 0; l < 4; l++) send(4 * w + l);
    in_valid = 1'b0;
    repeat (3) tick;
    chk("full level", a_level, 16);
    for (int l = 0; l < 4; l++) send(64 + l);
    in_valid = 1'b0;
    tick;
    tick;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("push+pop full level", a_level, 16);
    chk("push+pop full no overflow", a_ovf, 0);
    chk("push+pop head", a_data, wd(1));

    do_reset;
    send(10);
    send(11);
    enable = 1'b0;
    qin = 32'sd99;
    in_valid = 1'b1;
    repeat (5) tick;
    enable = 1'b1;
    send(12);
    send(13);
    in_valid = 1'b0;
    wait_a(n);
    chk("stall latency from first input", 8 + n, 11);
    chk("stall data", a_data, 32'h0D0C0B0A);
    chk("stall last", a_last, 1);
    pop;
    send(14);
    send(15);
    send(16);
    send(17);
    in_valid = 1'b0;
    enable = 1'b0;
    tick;
    tick;
    chk("held during tail stall", a_valid, 0);
    enable = 1'b1;
    wait_a(n);
    chk("tail stall latency", n, 3);
    chk("tail stall data", a_data, 32'h11100F0E);
    chk("tail stall level", a_level, 1);

    send(1);
    send(2);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async reset out_valid", a_valid, 0);
    chk("async reset out_data", a_data, 0);
    chk("async reset out_last", a_last, 0);
    chk("async reset level", a_level, 0);
    chk("async reset overflow", a_ovf, 0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    mult = 32'sd1;
    shift = 6'd0;
    for (int i = 21; i <= 24; i++) send(i);
    in_valid = 1'b0;
    wait_a(n);
    chk("post-reset data", a_data, 32'h18171615);
    chk("post-reset last", a_last, 1);
    chk("post-reset level", a_level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ln_requant_pack.md
# ln_requant_pack

Downstream stage of `layer_norm`. It takes the int32 normalized element stream and requantizes each element to int8 with a fixed-point multiply, rounding shift and saturation. It packs LANES int8 results per output word, marks the final word of each N-element vector, and buffers words in a FIFO behind a valid/ready handshake. The upstream stage has no backpressure, so buffer overrun is detected and flagged instead of stalled.

## Interface
Parameters:
- `D_W`, 8: output element width (int8).
- `D_W_ACC`, 32: input and multiplier width.
- `N`, 768: elements per vector.
- `LANES`, 4: int8 elements per output word.
- `FIFO_DEPTH`, 16: output FIFO depth in words; must be a power of 2.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `enable`  in  1: advances the input pipeline and packer; when low, these hold.
- `in_valid`  in  1: `qin` is valid this cycle (from `layer_norm` `out_valid`).
- `qin`  in  D_W_ACC signed: normalized element.
- `mult`  in  D_W_ACC signed: requant multiplier; static for the duration of a vector.
- `shift`  in  6: rounding right shift, 0..63; static for the duration of a vector.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts the word.
- `out_data`  out  LANES*D_W: packed word; lane k occupies bits [k*D_W +: D_W].
- `out_last`  out  1: word holds element N-1 of a vector.
- `level`  out  $clog2(FIFO_DEPTH)+1: FIFO occupancy in words.
- `overflow`  out  1: sticky; set when a completed word was dropped.

## Operation
- **S1.** On `enable && in_valid`, register `p = qin * mult` as a 2*D_W_ACC signed full product. In the same cycle, register `last = (elem_cnt == N-1)`. `elem_cnt` wraps N-1 → 0.
- **S2.** Rounding shift, round half toward +inf:
  - `r = (p + (shift ? 1<<(shift-1) : 0)) >>> shift`.
  - The add is done at 2*D_W_ACC+1 bits and cannot overflow.
  - `shift = 0` passes `p` through unchanged.
- **S3.** Saturate `r` to [-2^(D_W-1), 2^(D_W-1)-1], i.e. [-128, 127].
- Each stage carries a valid bit. Stages advance only when `enable = 1`. With `enable = 0`, all stage contents, valid bits, `elem_cnt` and the packer hold.
- **Packer.**
  - Write the S3 result into lane `lane_idx` and increment `lane_idx`.
  - A word completes when `lane_idx == LANES-1` or the element's `last` is set.
  - On completion: push `{last, word}` to the FIFO, reset `lane_idx` to 0, and clear the word register.
  - Lanes not written in a partial final word are 0.
- **FIFO.**
  - Push on word completion; pop on `out_valid && out_ready`.
  - Push while full with no pop in the same cycle: the word is dropped and `overflow` is set. `overflow` stays set until reset.
  - Push and pop in the same cycle when full: both take effect, and `level` is unchanged.
  - Push and pop in the same cycle when empty: not possible. The new word becomes visible the next cycle.
  - The FIFO output side ignores `enable`. Pops proceed while `enable = 0`.
- **Reset, including mid-vector:**
  - Clears `elem_cnt`, `lane_idx`, the partial word, stage valid bits and the FIFO.
  - Clears `overflow`.
  - In-flight elements are discarded.

## Timing
- Output reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `level`=0, `overflow`=0.
- Latency, with `enable` held high and the FIFO empty:
  - Element accepted at edge t, with the sample taken at t.
  - S1 at t, S2 at t+1, S3 at t+2, packer/FIFO write at t+3.
  - If that element completes a word, `out_valid` is high after edge t+3, i.e. visible in cycle t+4.
- Throughput: one element per cycle; one word per LANES cycles, or fewer for a partial final word.
- `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- `level` updates on the same edge as the push/pop that changes it.
- Every stall cycle (`enable = 0`) adds exactly one cycle to input-side latency.

## Test plan
1. **Requant and saturation.**
   - Stimulus: `mult`=65536, `shift`=16, N=4, qin = 5, -3, 130, -200.
   - Required: one word, `out_data`=0x807FFD05, `out_last`=1.
   - Required: `out_valid` rises 4 cycles after the 4th input.
2. **Rounding.**
   - Stimulus: `mult`=1, `shift`=1, qin = 3, -3, 2, -1.
   - Required: outputs 2, -1, 1, 0.
   - Stimulus: `shift`=0, qin=-7.
   - Required: output -7.
3. **Partial word.**
   - Stimulus: N=6, LANES=4, qin = 1..6 (unit scale).
   - Required: word 0x04030201 with `out_last`=0, then 0x00000605 with `out_last`=1.
   - Required: the `elem_cnt` wrap starts the next vector at lane 0.
4. **Overflow.**
   - Stimulus: `out_ready`=0; stream 17 full words.
   - Required: `level`=16; the 17th word is dropped; `overflow`=1.
   - Stimulus: raise `out_ready`.
   - Required: 16 words drained in order; `overflow` remains 1.
   - Stimulus: push and pop on the same edge while full.
   - Required: `level` stays 16 and `overflow` is not set.
5. **Stall and reset.**
   - Stimulus: drop `enable` for 5 cycles mid-word.
   - Required: no data lost or duplicated; the word appears 5 cycles later.
   - Stimulus: assert `rst` mid-vector.
   - Required: all outputs return to reset values; the next vector packs from lane 0 with a correct `out_last`.
